// File: rtl/classifier_frame_feeder.sv
// Double-buffered pixel frame store between a raster pixel stream and a classifier.
// One bank fills from the stream while the classifier reads the other and releases it when done.
module classifier_frame_feeder #(
  parameter int FRAME_PIXELS = 784,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        pixel_in_data,
  input  logic              pixel_in_valid,
  output logic              pixel_in_ready,
  input  logic              classifier_input_valid_write_en,
  input  logic [7:0]        classifier_input_valid_write_data,
  output logic [7:0]        classifier_input_valid_read_data,
  input  logic [ADDR_W-1:0] classifier_input_address_a,
  output logic [15:0]       classifier_input_read_data_a,
  output logic [15:0]       frames_consumed
);

  localparam int CNT_W = $clog2(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  // Complete control state in one struct so checkers can bind to a single signal.
  typedef struct packed {
    bank_state_e      bank0;
    bank_state_e      bank1;
    logic             wr_bank;
    logic             rd_bank;
    logic [CNT_W-1:0] wr_count;
    logic [15:0]      frames_consumed;
  } feeder_state_t;

  feeder_state_t st, st_nxt;
  logic          rst_sync;
  logic [7:0]    mem0 [FRAME_PIXELS];
  logic [7:0]    mem1 [FRAME_PIXELS];
  logic [15:0]   rd_data_q, rd_data_nxt;
  bank_state_e   wr_state, rd_state;
  logic          input_valid, accept, frame_done, release_req;
  logic          unused_write_data_bits;

  // Reset asserts immediately; its release takes effect one edge later so the
  // first state update lands on the second rising edge after deassertion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync <= 1'b1;
    else       rst_sync <= 1'b0;
  end

  assign wr_state    = st.wr_bank ? st.bank1 : st.bank0;
  assign rd_state    = st.rd_bank ? st.bank1 : st.bank0;
  assign input_valid = (rd_state == FULL);

  // Handshake: a pixel transfers on a rising edge where pixel_in_valid and
  // pixel_in_ready are both 1; ready depends only on registered state.
  assign pixel_in_ready = !rst_sync && (wr_state != FULL);
  assign accept         = pixel_in_valid && pixel_in_ready;
  assign frame_done     = accept && (st.wr_count == LAST_IDX);
  assign release_req    = classifier_input_valid_write_en &&
                          !classifier_input_valid_write_data[0] && input_valid;

  always_comb begin
    st_nxt = st;
    if (accept) begin
      if (frame_done) begin
        if (st.wr_bank) st_nxt.bank1 = FULL;
        else            st_nxt.bank0 = FULL;
        st_nxt.wr_count = '0;
        st_nxt.wr_bank  = !st.wr_bank;
      end else begin
        st_nxt.wr_count = st.wr_count + 1'b1;
        if (wr_state == EMPTY) begin
          if (st.wr_bank) st_nxt.bank1 = FILLING;
          else            st_nxt.bank0 = FILLING;
        end
      end
    end
    // A release only targets a FULL bank and writes never target one, so the
    // two updates above and below never touch the same bank.
    if (release_req) begin
      if (st.rd_bank) st_nxt.bank1 = EMPTY;
      else            st_nxt.bank0 = EMPTY;
      st_nxt.rd_bank         = !st.rd_bank;
      st_nxt.frames_consumed = st.frames_consumed + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          st <= '0;
    else if (!rst_sync) st <= st_nxt;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (st.wr_bank) mem1[st.wr_count] <= pixel_in_data;
      else            mem0[st.wr_count] <= pixel_in_data;
    end
  end

  always_comb begin
    rd_data_nxt = '0;
    if (32'(classifier_input_address_a) < FRAME_PIXELS) begin
      rd_data_nxt = {8'h00, st.rd_bank ? mem1[classifier_input_address_a]
                                       : mem0[classifier_input_address_a]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rd_data_q <= '0;
    else if (!rst_sync) rd_data_q <= rd_data_nxt;
  end

  assign unused_write_data_bits           = ^classifier_input_valid_write_data[7:1];
  assign classifier_input_valid_read_data = {7'b0, input_valid};
  assign classifier_input_read_data_a     = rd_data_q;
  assign frames_consumed                  = st.frames_consumed;

endmodule

// File: tb/tb_classifier_frame_feeder.sv
// Directed bench for classifier_frame_feeder: streaming, back-pressure,
// release semantics, out-of-range reads and mid-frame reset.
module tb_classifier_frame_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pixel_in_data;
  logic        pixel_in_valid;
  logic        pixel_in_ready;
  logic        classifier_input_valid_write_en;
  logic [7:0]  classifier_input_valid_write_data;
  logic [7:0]  classifier_input_valid_read_data;
  logic [9:0]  classifier_input_address_a;
  logic [15:0] classifier_input_read_data_a;
  logic [15:0] frames_consumed;

  int tests_run    = 0;
  int tests_failed = 0;
  bit stream_abort = 0;

  classifier_frame_feeder #(.FRAME_PIXELS(784), .ADDR_W(10)) dut (
    .clk                               (clk),
    .reset                             (reset),
    .pixel_in_data                     (pixel_in_data),
    .pixel_in_valid                    (pixel_in_valid),
    .pixel_in_ready                    (pixel_in_ready),
    .classifier_input_valid_write_en   (classifier_input_valid_write_en),
    .classifier_input_valid_write_data (classifier_input_valid_write_data),
    .classifier_input_valid_read_data  (classifier_input_valid_read_data),
    .classifier_input_address_a        (classifier_input_address_a),
    .classifier_input_read_data_a      (classifier_input_read_data_a),
    .frames_consumed                   (frames_consumed)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    pixel_in_valid                    = 1'b0;
    pixel_in_data                     = 8'h00;
    classifier_input_valid_write_en   = 1'b0;
    classifier_input_valid_write_data = 8'h00;
    reset = 1'b1;
    repeat (3) step();
    check("rst_read_data", 32'(classifier_input_read_data_a), 32'h0);
    check("rst_input_valid", 32'(classifier_input_valid_read_data), 32'h0);
    check("rst_frames", 32'(frames_consumed), 32'h0);
    reset = 1'b0;
    step();
    check("rst_ready", 32'(pixel_in_ready), 32'h1);
  endtask

  task automatic send_pixel(input logic [7:0] d);
    int waited = 0;
    pixel_in_data  = d;
    pixel_in_valid = 1'b1;
    while (!pixel_in_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!pixel_in_ready) begin
      check("pixel_accept_timeout", 32'(pixel_in_ready), 32'h1);
      stream_abort = 1'b1;
    end else begin
      step();
    end
  endtask

  task automatic stream(input int n, input logic [7:0] fill, input bit use_idx);
    for (int i = 0; i < n; i++) begin
      if (!stream_abort) send_pixel(use_idx ? (8'(i) ^ fill) : fill);
    end
    pixel_in_valid = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [9:0] addr, input logic [15:0] exp);
    classifier_input_address_a = addr;
    step();
    check(tag, 32'(classifier_input_read_data_a), 32'(exp));
  endtask

  task automatic valid_write(input logic [7:0] d);
    classifier_input_valid_write_en   = 1'b1;
    classifier_input_valid_write_data = d;
    step();
    classifier_input_valid_write_en   = 1'b0;
  endtask

  initial begin
    classifier_input_address_a = 10'd0;
    do_reset();

    // One index-valued frame, readback, out-of-range reads, release
    stream(783, 8'h00, 1'b1);
    check("f0_not_valid_before_last", 32'(classifier_input_valid_read_data), 32'h0);
    stream(1, 8'h0F, 1'b0);
    check("f0_valid_after_last", 32'(classifier_input_valid_read_data), 32'h1);
    read_check("f0_addr5", 10'd5, 16'h0005);
    read_check("f0_addr0", 10'd0, 16'h0000);
    read_check("f0_addr300", 10'd300, 16'h002C);
    read_check("f0_addr783", 10'd783, 16'h000F);
    read_check("f0_addr784", 10'd784, 16'h0000);
    read_check("f0_addr1023", 10'd1023, 16'h0000);
    valid_write(8'h00);
    check("f0_release_frames", 32'(frames_consumed), 32'h1);
    check("f0_release_valid", 32'(classifier_input_valid_read_data), 32'h0);
    valid_write(8'h00);
    check("invalid_write_frames", 32'(frames_consumed), 32'h1);
    check("invalid_write_valid", 32'(classifier_input_valid_read_data), 32'h0);

    // Three frames without release: back-pressure, ignored writes, release
    do_reset();
    stream(784, 8'h11, 1'b0);
    stream(783, 8'h22, 1'b0);
    check("bp_ready_before_1568", 32'(pixel_in_ready), 32'h1);
    stream(1, 8'h22, 1'b0);
    check("bp_ready_after_1568", 32'(pixel_in_ready), 32'h0);
    pixel_in_data  = 8'h33;
    pixel_in_valid = 1'b1;
    repeat (5) step();
    check("bp_stall_ready", 32'(pixel_in_ready), 32'h0);
    check("bp_stall_valid", 32'(classifier_input_valid_read_data), 32'h1);
    read_check("bp_addr0_frame1", 10'd0, 16'h0011);
    valid_write(8'h01);
    check("write1_frames", 32'(frames_consumed), 32'h0);
    check("write1_valid", 32'(classifier_input_valid_read_data), 32'h1);
    check("write1_ready", 32'(pixel_in_ready), 32'h0);
    read_check("write1_rd_bank", 10'd0, 16'h0011);
    valid_write(8'h00);
    check("rel_frames", 32'(frames_consumed), 32'h1);
    check("rel_ready_next_cycle", 32'(pixel_in_ready), 32'h1);
    check("rel_valid_other_full", 32'(classifier_input_valid_read_data), 32'h1);
    step();
    pixel_in_valid = 1'b0;
    check("rel_addr0_frame2", 32'(classifier_input_read_data_a), 32'h0022);

    // Frame completion and release on the same edge
    do_reset();
    stream(784, 8'h11, 1'b0);
    stream(783, 8'h22, 1'b0);
    check("same_edge_ready", 32'(pixel_in_ready), 32'h1);
    pixel_in_data                     = 8'h22;
    pixel_in_valid                    = 1'b1;
    classifier_input_valid_write_en   = 1'b1;
    classifier_input_valid_write_data = 8'h00;
    step();
    pixel_in_valid                  = 1'b0;
    classifier_input_valid_write_en = 1'b0;
    check("same_edge_valid", 32'(classifier_input_valid_read_data), 32'h1);
    check("same_edge_frames", 32'(frames_consumed), 32'h1);
    check("same_edge_ready_after", 32'(pixel_in_ready), 32'h1);
    read_check("same_edge_addr0", 10'd0, 16'h0022);
    valid_write(8'h00);
    check("same_edge_second_release", 32'(frames_consumed), 32'h2);
    check("same_edge_valid_drop", 32'(classifier_input_valid_read_data), 32'h0);

    // Reset mid-frame, then a fresh frame
    do_reset();
    stream(400, 8'h00, 1'b1);
    read_check("partial_stale_addr5", 10'd5, 16'h0005);
    check("partial_not_valid", 32'(classifier_input_valid_read_data), 32'h0);
    do_reset();
    stream(784, 8'h5A, 1'b1);
    check("fresh_valid", 32'(classifier_input_valid_read_data), 32'h1);
    read_check("fresh_addr0", 10'd0, 16'h005A);
    read_check("fresh_addr400", 10'd400, 16'h00CA);
    read_check("fresh_addr783", 10'd783, 16'h0055);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
